// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: port indices, issue-entry
// control fields and default geometry.
package dmem_arb_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 32;
  localparam int DEPTH_DEF  = 64;

  typedef enum logic {
    PORT_CORE = 1'b0,
    PORT_DMA  = 1'b1
  } port_e;

  // Control half of the issue entry; address and data widths follow the
  // top-level parameters and are held alongside it.
  typedef struct packed {
    logic  valid;
    port_e port;
    logic  we;
  } issue_ctrl_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter. A lone requester wins every cycle; under
// contention the port that did not win last is granted.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

  port_e prio;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    gnt = req;
    if (req == 2'b11) begin
      gnt = (prio == PORT_CORE) ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prio <= PORT_CORE;
    end else if (accept) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of block order.
      prio <= gnt[0] ? PORT_DMA : PORT_CORE;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin sharing of the single-port data memory between the core LSU
// (port 0) and a DMA/debug master (port 1), with a one-entry issue stage.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              oor,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] read_address,
  output logic [DATA_W-1:0] Write_data,
  input  logic [DATA_W-1:0] MemData_in
);

  logic [1:0]        gnt;
  logic              accept;
  issue_ctrl_t       iss;
  logic [ADDR_W-1:0] iss_addr;
  logic [DATA_W-1:0] iss_wdata;
  logic              in_range;
  logic [1:0]        ret_valid;
  logic [DATA_W-1:0] ret_data;

  assign accept = |gnt;

  rr_arb2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    ({req1, req0}),
    .accept (accept),
    .gnt    (gnt)
  );

  assign gnt0 = gnt[0];
  assign gnt1 = gnt[1];

  // Loaded every edge; the payload of an idle cycle is don't-care because
  // all memory-side outputs are qualified by valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      iss       <= '0;
      iss_addr  <= '0;
      iss_wdata <= '0;
    end else begin
      iss.valid <= accept;
      iss.port  <= gnt[1] ? PORT_DMA : PORT_CORE;
      iss.we    <= gnt[1] ? we1 : we0;
      iss_addr  <= gnt[1] ? addr1 : addr0;
      iss_wdata <= gnt[1] ? wdata1 : wdata0;
    end
  end

  assign in_range     = (iss_addr < ADDR_W'(DEPTH));
  assign MemRead      = iss.valid & ~iss.we & in_range;
  assign MemWrite     = iss.valid & iss.we & in_range;
  assign oor          = iss.valid & ~in_range;
  assign read_address = iss.valid ? iss_addr : '0;
  assign Write_data   = iss.valid ? iss_wdata : '0;

  // Read data is captured at the end of the issue cycle; an out-of-range
  // read still completes, with zero data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ret_valid <= 2'b00;
      ret_data  <= '0;
    end else begin
      ret_valid <= 2'b00;
      if (iss.valid && !iss.we) begin
        ret_valid <= (iss.port == PORT_DMA) ? 2'b10 : 2'b01;
        ret_data  <= in_range ? MemData_in : '0;
      end
    end
  end

  assign rvalid0 = ret_valid[0];
  assign rvalid1 = ret_valid[1];
  assign rdata0  = ret_valid[0] ? ret_data : '0;
  assign rdata1  = ret_valid[1] ? ret_data : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized
// traffic scored against a transaction-level model of memory and ordering.
module tb_dmem_arbiter;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 64;

  logic          clk;
  logic          reset;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1, oor, MemRead, MemWrite;
  logic [DW-1:0] rdata0, rdata1, Write_data, MemData_in;
  logic [AW-1:0] read_address;

  dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .req0         (req0),
    .req1         (req1),
    .we0          (we0),
    .we1          (we1),
    .addr0        (addr0),
    .addr1        (addr1),
    .wdata0       (wdata0),
    .wdata1       (wdata1),
    .gnt0         (gnt0),
    .gnt1         (gnt1),
    .rvalid0      (rvalid0),
    .rvalid1      (rvalid1),
    .rdata0       (rdata0),
    .rdata1       (rdata1),
    .oor          (oor),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite),
    .read_address (read_address),
    .Write_data   (Write_data),
    .MemData_in   (MemData_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory slave: combinational read, write on the edge; out-of-range reads
  // return a marker so that zeroing by the arbiter is observable.
  logic [DW-1:0] tb_mem [DEPTH];
  always_comb begin
    MemData_in = 32'hA5A5_0000 | read_address;
    if (read_address < AW'(DEPTH)) MemData_in = tb_mem[read_address[5:0]];
  end
  always @(posedge clk) begin
    if (MemWrite && read_address < AW'(DEPTH)) tb_mem[read_address[5:0]] <= Write_data;
  end

  // Reference model: sequential memory image plus queues of completions
  // stamped with the cycle they must appear in.
  typedef struct {
    int          due;
    logic        port;
    logic        we;
    logic        inr;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  logic [DW-1:0] ref_mem [DEPTH];
  txn_t acc_q[$];
  txn_t ret_q[$];
  int   last_port;
  int   cyc;
  int   checks;
  int   errors;

  task automatic step(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                      input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                      output logic og0, output logic og1);
    txn_t        t;
    logic        eg0, eg1, e_mr, e_mw, e_oor;
    logic [31:0] e_addr, e_wd, e_rd0, e_rd1;
    logic [1:0]  e_rv;
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    #1;
    e_mr = 0; e_mw = 0; e_oor = 0; e_addr = 0; e_wd = 0;
    e_rv = 2'b00; e_rd0 = 0; e_rd1 = 0;
    if (acc_q.size() > 0 && acc_q[0].due == cyc) begin
      t      = acc_q.pop_front();
      e_mr   = !t.we && t.inr;
      e_mw   = t.we && t.inr;
      e_oor  = !t.inr;
      e_addr = t.addr;
      e_wd   = t.data;
    end
    if (ret_q.size() > 0 && ret_q[0].due == cyc) begin
      t = ret_q.pop_front();
      if (t.port) begin e_rv = 2'b10; e_rd1 = t.data; end
      else        begin e_rv = 2'b01; e_rd0 = t.data; end
    end
    checks += 6;
    if ({MemRead, MemWrite, oor} !== {e_mr, e_mw, e_oor}) begin
      errors++;
      $display("FAIL strobes cyc %0d: got rd/wr/oor %b expected %b", cyc, {MemRead, MemWrite, oor}, {e_mr, e_mw, e_oor});
    end
    if (read_address !== e_addr) begin
      errors++;
      $display("FAIL read_address cyc %0d: got %h expected %h", cyc, read_address, e_addr);
    end
    if ((e_mw || !(e_mr || e_oor)) && Write_data !== e_wd) begin
      errors++;
      $display("FAIL Write_data cyc %0d: got %h expected %h", cyc, Write_data, e_wd);
    end
    if ({rvalid1, rvalid0} !== e_rv) begin
      errors++;
      $display("FAIL rvalid cyc %0d: got %b expected %b", cyc, {rvalid1, rvalid0}, e_rv);
    end
    if (rdata0 !== e_rd0 || rdata1 !== e_rd1) begin
      errors++;
      $display("FAIL rdata cyc %0d: got %h/%h expected %h/%h", cyc, rdata0, rdata1, e_rd0, e_rd1);
    end
    eg0 = r0 && (!r1 || last_port == 1);
    eg1 = r1 && (!r0 || last_port == 0);
    if ({gnt1, gnt0} !== {eg1, eg0}) begin
      errors++;
      $display("FAIL gnt cyc %0d: got %b expected %b", cyc, {gnt1, gnt0}, {eg1, eg0});
    end
    og0 = gnt0;
    og1 = gnt1;
    if (eg0 || eg1) begin
      t.port = eg1;
      t.we   = eg1 ? w1 : w0;
      t.addr = eg1 ? a1 : a0;
      t.data = eg1 ? d1 : d0;
      t.inr  = t.addr < DEPTH;
      t.due  = cyc + 1;
      acc_q.push_back(t);
      if (t.we) begin
        if (t.inr) ref_mem[t.addr[5:0]] = t.data;
      end else begin
        t.due  = cyc + 2;
        t.data = t.inr ? ref_mem[t.addr[5:0]] : 32'h0;
        ret_q.push_back(t);
      end
      last_port = eg1 ? 1 : 0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    logic g0, g1;
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, g0, g1);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req0 = 0; req1 = 0;
    acc_q.delete();
    ret_q.delete();
    last_port = 1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    cyc++;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req0 = 1; req1 = 0; we0 = 0; we1 = 0; addr0 = 3; addr1 = 4; wdata0 = 0; wdata1 = 0;
    #1;
    checks += 3;
    if ({MemRead, MemWrite, oor, rvalid0, rvalid1} !== 5'b0) begin
      errors++;
      $display("FAIL reset_strobes: got %b expected 00000", {MemRead, MemWrite, oor, rvalid0, rvalid1});
    end
    if (read_address !== 0 || Write_data !== 0 || rdata0 !== 0 || rdata1 !== 0) begin
      errors++;
      $display("FAIL reset_buses: got %h %h %h %h expected all 0", read_address, Write_data, rdata0, rdata1);
    end
    if ({gnt1, gnt0} !== 2'b01) begin
      errors++;
      $display("FAIL reset_gnt_req0: got %b expected 01", {gnt1, gnt0});
    end
    req0 = 0; req1 = 1;
    #1;
    checks++;
    if ({gnt1, gnt0} !== 2'b10) begin
      errors++;
      $display("FAIL reset_gnt_req1: got %b expected 10", {gnt1, gnt0});
    end
    req0 = 1;
    #1;
    checks++;
    if ({gnt1, gnt0} !== 2'b01) begin
      errors++;
      $display("FAIL reset_gnt_both: got %b expected 01", {gnt1, gnt0});
    end
    do_reset();
  endtask

  task automatic test_write_read();
    logic g0, g1;
    step(1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, g0, g1);
    checks++;
    if (!(MemWrite === 1'b1 && read_address === 5)) begin
      errors++;
      $display("FAIL wr_issue: got MemWrite %b addr %h expected 1 addr 5", MemWrite, read_address);
    end
    step(1, 0, 5, 0, 0, 0, 0, 0, g0, g1);
    idle(1);
    checks++;
    if (!(rvalid0 === 1'b1 && rdata0 === 32'hDEADBEEF && rvalid1 === 1'b0)) begin
      errors++;
      $display("FAIL rd_return: got rvalid0 %b rdata0 %h rvalid1 %b expected 1 deadbeef 0", rvalid0, rdata0, rvalid1);
    end
    idle(1);
  endtask

  task automatic test_contention();
    logic        g0, g1;
    logic [31:0] v1, v2;
    v1 = $urandom;
    v2 = $urandom;
    step(1, 1, 1, v1, 0, 0, 0, 0, g0, g1);
    step(1, 1, 2, v2, 0, 0, 0, 0, g0, g1);
    idle(2);
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 1, 0, 1, 0, 2, 0, g0, g1);
      checks++;
      if ({g1, g0} !== ((i % 2 == 1) ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL contention_gnt %0d: got %b", i, {g1, g0});
      end
      if (i >= 1) begin
        checks++;
        if ((i - 1) % 2 == 0 ? (rvalid0 !== 1'b1 || rdata0 !== v1) : (rvalid1 !== 1'b1 || rdata1 !== v2)) begin
          errors++;
          $display("FAIL contention_ret %0d: got %b %h %h", i, {rvalid1, rvalid0}, rdata0, rdata1);
        end
      end
    end
    idle(2);
  endtask

  task automatic test_back_to_back();
    logic g0, g1;
    step(0, 0, 0, 0, 1, 1, 10, 32'h1234, g0, g1);
    step(1, 0, 10, 0, 0, 0, 0, 0, g0, g1);
    idle(1);
    checks++;
    if (rvalid0 !== 1'b1 || rdata0 !== 32'h1234) begin
      errors++;
      $display("FAIL raw: got rvalid0 %b rdata0 %h expected 1 00001234", rvalid0, rdata0);
    end
    idle(1);
  endtask

  task automatic test_out_of_range();
    logic        g0, g1;
    logic [31:0] w0_before;
    w0_before = tb_mem[0];
    step(1, 1, 64, 32'h0BAD_0BAD, 0, 0, 0, 0, g0, g1);
    checks++;
    if (MemWrite !== 1'b0 || oor !== 1'b1) begin
      errors++;
      $display("FAIL oor_write: got MemWrite %b oor %b expected 0 1", MemWrite, oor);
    end
    step(0, 0, 0, 0, 1, 0, 100, 0, g0, g1);
    checks++;
    if (tb_mem[0] !== w0_before || oor !== 1'b1 || MemRead !== 1'b0) begin
      errors++;
      $display("FAIL oor_read_issue: got mem0 %h oor %b MemRead %b expected %h 1 0", tb_mem[0], oor, MemRead, w0_before);
    end
    idle(1);
    checks++;
    if (rvalid1 !== 1'b1 || rdata1 !== 0) begin
      errors++;
      $display("FAIL oor_read_ret: got rvalid1 %b rdata1 %h expected 1 0", rvalid1, rdata1);
    end
    idle(1);
  endtask

  task automatic test_reset_mid_read();
    logic g0, g1;
    step(1, 0, 5, 0, 0, 0, 0, 0, g0, g1);
    checks++;
    if (MemRead !== 1'b1) begin
      errors++;
      $display("FAIL midrst_issue: got MemRead %b expected 1", MemRead);
    end
    req0 = 0;
    reset = 1'b0;
    #1;
    checks++;
    if ({MemRead, MemWrite, oor, rvalid0, rvalid1} !== 5'b0 || read_address !== 0 || rdata0 !== 0) begin
      errors++;
      $display("FAIL midrst_clear: got %b addr %h rdata0 %h expected all 0",
               {MemRead, MemWrite, oor, rvalid0, rvalid1}, read_address, rdata0);
    end
    acc_q.delete();
    ret_q.delete();
    last_port = 1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    cyc++;
    idle(1);
    step(1, 0, 1, 0, 1, 0, 2, 0, g0, g1);
    checks++;
    if ({g1, g0} !== 2'b01) begin
      errors++;
      $display("FAIL midrst_prio: got %b expected 01", {g1, g0});
    end
    step(0, 0, 0, 0, 1, 0, 2, 0, g0, g1);
    idle(2);
  endtask

  task automatic test_stream();
    logic g0, g1;
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 0, 1, 1, i, 32'h5000 + i, g0, g1);
      checks++;
      if (g1 !== 1'b1 || g0 !== 1'b0 || MemWrite !== 1'b1 || read_address !== i) begin
        errors++;
        $display("FAIL stream %0d: got gnt %b MemWrite %b addr %h expected 10 1 %h", i, {g1, g0}, MemWrite, read_address, i);
      end
    end
    idle(2);
  endtask

  task automatic test_random();
    logic        g0, g1;
    logic        p_r0, p_w0, p_r1, p_w1;
    logic [31:0] p_a0, p_d0, p_a1, p_d1;
    p_r0 = 0; p_r1 = 0; p_w0 = 0; p_w1 = 0; p_a0 = 0; p_a1 = 0; p_d0 = 0; p_d1 = 0;
    for (int i = 0; i < 400; i++) begin
      if (!p_r0 && $urandom_range(0, 9) < 6) begin
        p_r0 = 1; p_w0 = 1'($urandom_range(0, 1));
        p_a0 = $urandom_range(0, 79); p_d0 = $urandom;
      end
      if (!p_r1 && $urandom_range(0, 9) < 6) begin
        p_r1 = 1; p_w1 = 1'($urandom_range(0, 1));
        p_a1 = $urandom_range(0, 79); p_d1 = $urandom;
      end
      step(p_r0, p_w0, p_a0, p_d0, p_r1, p_w1, p_a1, p_d1, g0, g1);
      if (g0) p_r0 = 0;
      if (g1) p_r1 = 0;
    end
    idle(3);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    cyc       = 0;
    last_port = 1;
    for (int i = 0; i < DEPTH; i++) begin
      tb_mem[i]  = $urandom;
      ref_mem[i] = tb_mem[i];
    end
    test_reset();
    test_write_read();
    test_contention();
    test_back_to_back();
    test_out_of_range();
    test_reset_mid_read();
    test_stream();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
